// File: rtl/noise_ctrl_pkg.sv
// Shared types and constants for the CDF noise generator sequencer.
// Holds the controller state encoding, sticky error codes and default sizes.
package noise_ctrl_pkg;

  localparam int DEPTH_DEF  = 128;
  localparam int DATA_W_DEF = 64;
  localparam int CNT_W_DEF  = 32;
  localparam int WDOG_W_DEF = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_READY = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_NONMONO = 2'd1;
  localparam logic [1:0] ERR_STALL   = 2'd2;
  localparam logic [1:0] ERR_ZEROLEN = 2'd3;

endpackage

// File: rtl/noise_cdf_loader.sv
// Table-load datapath: indexes accepted CDF words, issues the registered RAM
// write one cycle after each handshake, and checks the table is non-decreasing.
module noise_cdf_loader
  import noise_ctrl_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start_i,
  input  logic              accept_i,
  input  logic [DATA_W-1:0] cfg_data_i,
  output logic              tbl_we_o,
  output logic [AW-1:0]     tbl_addr_o,
  output logic [DATA_W-1:0] tbl_wdata_o,
  output logic              load_done_o,
  output logic              load_err_o
);

  localparam logic [AW-1:0] IDX_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);

  logic [AW-1:0]     idx_q;
  logic [DATA_W-1:0] prev_q;
  logic              bad_q;
  logic              bad_now_s;
  logic              tbl_we_q;
  logic [AW-1:0]     tbl_addr_q;
  logic [DATA_W-1:0] tbl_wdata_q;

  // Equal neighbours are legal (empty bin); only a strict decrease is an error.
  always_comb begin
    bad_now_s   = accept_i && (idx_q != {AW{1'b0}}) && (cfg_data_i < prev_q);
    load_done_o = accept_i && (idx_q == IDX_LAST);
    load_err_o  = bad_q | bad_now_s;
  end

  // Index, previous word, sticky monotonic flag and the registered write port.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx_q       <= {AW{1'b0}};
      prev_q      <= {DATA_W{1'b0}};
      bad_q       <= 1'b0;
      tbl_we_q    <= 1'b0;
      tbl_addr_q  <= {AW{1'b0}};
      tbl_wdata_q <= {DATA_W{1'b0}};
    end else begin
      tbl_we_q <= accept_i;
      if (start_i) begin
        idx_q <= {AW{1'b0}};
        bad_q <= 1'b0;
      end else if (accept_i) begin
        idx_q       <= idx_q + IDX_ONE;
        prev_q      <= cfg_data_i;
        bad_q       <= bad_q | bad_now_s;
        tbl_addr_q  <= idx_q;
        tbl_wdata_q <= cfg_data_i;
      end
    end
  end

  assign tbl_we_o    = tbl_we_q;
  assign tbl_addr_o  = tbl_addr_q;
  assign tbl_wdata_o = tbl_wdata_q;

endmodule

// File: rtl/noise_gen_ctrl.sv
// Sequencer for the 128-bin CDF noise generator: table load, burst run with a
// stall watchdog, and sticky error reporting toward the host.
module noise_gen_ctrl
  import noise_ctrl_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int WDOG_W = WDOG_W_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load_start,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              run_start,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic              abort,
  output logic              tbl_we,
  output logic [AW-1:0]     tbl_addr,
  output logic [DATA_W-1:0] tbl_wdata,
  output logic              gen_en,
  input  logic              gen_valid,
  output logic              busy,
  output logic              table_ok,
  output logic              done,
  output logic [1:0]        err,
  output logic [CNT_W-1:0]  sample_cnt
);

  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WDOG_W-1:0] WDOG_ONE = {{(WDOG_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic               gen_en_q, gen_en_d;
  logic               table_ok_q, table_ok_d;
  logic               done_q, done_d;
  logic [1:0]         err_q, err_d;
  logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0]   burst_q, burst_d;
  logic [WDOG_W-1:0]  wdog_q, wdog_d;
  logic [WDOG_W-1:0]  wdog_inc_s;
  logic               ld_start_s;
  logic               accept_s;
  logic               load_done_s;
  logic               load_err_s;

  // abort blocks the handshake in the same cycle so no word slips through.
  assign cfg_ready = (state_q == ST_LOAD) && !abort;
  assign accept_s  = cfg_valid && cfg_ready;
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_RUN);

  noise_cdf_loader #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_loader (
    .clk         (clk),
    .rstn        (rstn),
    .start_i     (ld_start_s),
    .accept_i    (accept_s),
    .cfg_data_i  (cfg_data),
    .tbl_we_o    (tbl_we),
    .tbl_addr_o  (tbl_addr),
    .tbl_wdata_o (tbl_wdata),
    .load_done_o (load_done_s),
    .load_err_o  (load_err_s)
  );

  // Next-state and next-output decode; abort overrides every other event.
  always_comb begin
    state_d      = state_q;
    gen_en_d     = gen_en_q;
    table_ok_d   = table_ok_q;
    done_d       = 1'b0;
    err_d        = err_q;
    sample_cnt_d = sample_cnt_q;
    burst_d      = burst_q;
    wdog_d       = wdog_q;
    ld_start_s   = 1'b0;
    wdog_inc_s   = wdog_q + WDOG_ONE;

    if (abort) begin
      state_d    = ST_IDLE;
      gen_en_d   = 1'b0;
      table_ok_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ERR: begin
          if (load_start) begin
            state_d    = ST_LOAD;
            err_d      = ERR_NONE;
            table_ok_d = 1'b0;
            ld_start_s = 1'b1;
          end else begin
            state_d = state_q;
          end
        end
        ST_LOAD: begin
          if (load_err_s) begin
            err_d = ERR_NONMONO;
          end else begin
            err_d = err_q;
          end
          if (load_done_s) begin
            if (load_err_s) begin
              state_d    = ST_ERR;
              table_ok_d = 1'b0;
            end else begin
              state_d    = ST_READY;
              table_ok_d = 1'b1;
            end
          end else begin
            state_d = ST_LOAD;
          end
        end
        ST_READY, ST_DONE: begin
          if (load_start) begin
            state_d    = ST_LOAD;
            err_d      = ERR_NONE;
            table_ok_d = 1'b0;
            ld_start_s = 1'b1;
          end else if (run_start) begin
            if (burst_len == {CNT_W{1'b0}}) begin
              state_d    = ST_ERR;
              err_d      = ERR_ZEROLEN;
              table_ok_d = 1'b0;
            end else begin
              state_d      = ST_RUN;
              burst_d      = burst_len;
              sample_cnt_d = {CNT_W{1'b0}};
              wdog_d       = {WDOG_W{1'b0}};
              gen_en_d     = 1'b1;
            end
          end else begin
            state_d = state_q;
          end
        end
        ST_RUN: begin
          if (gen_valid) begin
            sample_cnt_d = sample_cnt_q + CNT_ONE;
            wdog_d       = {WDOG_W{1'b0}};
            if (sample_cnt_q == (burst_q - CNT_ONE)) begin
              state_d  = ST_DONE;
              gen_en_d = 1'b0;
              done_d   = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            wdog_d = wdog_inc_s;
            if (wdog_inc_s == {WDOG_W{1'b1}}) begin
              state_d    = ST_ERR;
              err_d      = ERR_STALL;
              gen_en_d   = 1'b0;
              table_ok_d = 1'b0;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        default: begin
          state_d    = ST_IDLE;
          gen_en_d   = 1'b0;
          table_ok_d = 1'b0;
        end
      endcase
    end
  end

  // State and registered-output flops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      gen_en_q     <= 1'b0;
      table_ok_q   <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= ERR_NONE;
      sample_cnt_q <= {CNT_W{1'b0}};
      burst_q      <= {CNT_W{1'b0}};
      wdog_q       <= {WDOG_W{1'b0}};
    end else begin
      state_q      <= state_d;
      gen_en_q     <= gen_en_d;
      table_ok_q   <= table_ok_d;
      done_q       <= done_d;
      err_q        <= err_d;
      sample_cnt_q <= sample_cnt_d;
      burst_q      <= burst_d;
      wdog_q       <= wdog_d;
    end
  end

  assign gen_en     = gen_en_q;
  assign table_ok   = table_ok_q;
  assign done       = done_q;
  assign err        = err_q;
  assign sample_cnt = sample_cnt_q;

endmodule
